// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with a valid/ready handshake on both sides.
// It holds one operation at a time. ADD, SUB and the logic ops finish in a
// single cycle. MUL uses a shift-add multiplier that runs for WIDTH cycles.
// DIV uses a restoring divider that runs for WIDTH cycles.
// All outputs are either registered or decoded from the FSM state.
//
// Optional feature: define ALU_DIV_EN to build the restoring divider.
// Without it, SEL=011 finishes in one cycle with OUT=0, OUT_HI=0 and ERR=1.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. IN_READY is high only in IDLE, and is low while RST is high.
// OUT_VALID is high only in DONE. While DONE waits for OUT_READY, the outputs
// stay stable.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       SEL,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT,
    output logic [WIDTH-1:0] OUT_HI,
    output logic             CARRY,
    output logic             ZERO,
    output logic             ERR,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_XNOR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Iteration registers. For MUL, acc holds {partial product high, multiplier}.
    // For DIV, acc holds {partial remainder, remaining dividend / quotient}.
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   b_q;
    logic [CW-1:0]      cnt_q;
`ifdef ALU_DIV_EN
    logic               is_mul_q;
`endif

    // Registered results
    logic [WIDTH-1:0] out_q, out_hi_q;
    logic             carry_q, zero_q, err_q;

    // Single-cycle decode, taken from the operands at the accept edge
    logic [WIDTH:0]   sum_w, diff_w;
    logic [WIDTH-1:0] sc_lo, sc_hi;
    logic             sc_carry, sc_err, sc_multi;

    // Iteration datapath
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] step_next;
    logic               fin_carry;
`ifdef ALU_DIV_EN
    logic [WIDTH:0]     rem_sh, div_diff;
    logic [2*WIDTH-1:0] div_next;
`endif

    logic accept, last_iter;

    assign accept    = (state_q == IDLE) && IN_VALID;
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    assign sum_w  = {1'b0, A} + {1'b0, B};
    assign diff_w = {1'b0, A} - {1'b0, B};

    assign IN_READY  = (state_q == IDLE) && !RST;
    assign OUT_VALID = (state_q == DONE);
    assign OUT       = out_q;
    assign OUT_HI    = out_hi_q;
    assign CARRY     = carry_q;
    assign ZERO      = zero_q;
    assign ERR       = err_q;
    assign dbg_state = state_q;

    // Decode the opcode into a single-cycle result, or flag it as multi-cycle
    always_comb begin
        sc_lo    = '0;
        sc_hi    = '0;
        sc_carry = 1'b0;
        sc_err   = 1'b0;
        sc_multi = 1'b0;
        unique case (SEL)
            OP_ADD: begin
                sc_lo    = sum_w[WIDTH-1:0];
                sc_carry = sum_w[WIDTH];
            end
            OP_SUB: begin
                sc_lo    = diff_w[WIDTH-1:0];
                sc_carry = diff_w[WIDTH];
            end
            OP_MUL: sc_multi = 1'b1;
            OP_DIV: begin
`ifdef ALU_DIV_EN
                if (B == '0) begin
                    sc_lo  = '1;
                    sc_hi  = A;
                    sc_err = 1'b1;
                end else begin
                    sc_multi = 1'b1;
                end
`else
                sc_err = 1'b1;
`endif
            end
            OP_AND:  sc_lo = A & B;
            OP_OR:   sc_lo = A | B;
            OP_XOR:  sc_lo = A ^ B;
            OP_XNOR: sc_lo = ~(A ^ B);
            default: sc_lo = '0;
        endcase
    end

    // One shift-add or restoring-divide step on the accumulator
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff = rem_sh - {1'b0, b_q};
        if (!div_diff[WIDTH]) begin
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        step_next = is_mul_q ? mul_next : div_next;
        fin_carry = is_mul_q && (mul_next[2*WIDTH-1:WIDTH] != '0);
`else
        step_next = mul_next;
        fin_carry = (mul_next[2*WIDTH-1:WIDTH] != '0);
`endif
    end

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (IN_VALID)  state_d = sc_multi ? BUSY : DONE;
            BUSY: if (last_iter) state_d = DONE;
            DONE: if (OUT_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch on accept, iterate in BUSY, register results
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc_q    <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
`ifdef ALU_DIV_EN
            is_mul_q <= 1'b0;
`endif
            out_q    <= '0;
            out_hi_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                if (sc_multi) begin
                    acc_q    <= {{WIDTH{1'b0}}, A};
                    b_q      <= B;
                    cnt_q    <= '0;
`ifdef ALU_DIV_EN
                    is_mul_q <= (SEL == OP_MUL);
`endif
                end else begin
                    out_q    <= sc_lo;
                    out_hi_q <= sc_hi;
                    carry_q  <= sc_carry;
                    zero_q   <= (sc_lo == '0);
                    err_q    <= sc_err;
                end
            end else if (state_q == BUSY) begin
                acc_q <= step_next;
                cnt_q <= cnt_q + CW'(1);
                if (last_iter) begin
                    out_q    <= step_next[WIDTH-1:0];
                    out_hi_q <= step_next[2*WIDTH-1:WIDTH];
                    carry_q  <= fin_carry;
                    zero_q   <= (step_next[WIDTH-1:0] == '0);
                    err_q    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu at WIDTH=8.
// Directed steps come first, then a block of random operations.
// Each step pushes its expected result into a queue when it drives the
// operation. The result is popped and compared when OUT_VALID appears.
module tb_seq_alu;

    localparam int W  = 8;
    localparam int RW = 2*W + 3;   // {out, out_hi, carry, zero, err}

    logic         CLK = 1'b0;
    logic         RST;
    logic         IN_VALID;
    logic         IN_READY;
    logic [W-1:0] A, B;
    logic [2:0]   SEL;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [W-1:0] OUT, OUT_HI;
    logic         CARRY, ZERO, ERR;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [RW-1:0] exp_q[$];

    seq_alu #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A(A), .B(B), .SEL(SEL), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT(OUT), .OUT_HI(OUT_HI), .CARRY(CARRY), .ZERO(ZERO), .ERR(ERR),
        .dbg_state(dbg_state)
    );

    // Clock
    always #5 CLK = ~CLK;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference model
    function automatic logic [RW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] sel);
        logic [W-1:0]   lo, hi;
        logic           c, e;
        logic [2*W-1:0] p;
        int unsigned    ai, bi;
        ai = a; bi = b;
        lo = '0; hi = '0; c = 1'b0; e = 1'b0; p = '0;
        case (sel)
            3'd0: begin lo = W'(ai + bi); c = (ai + bi) > ((1 << W) - 1); end
            3'd1: begin lo = W'(ai - bi); c = (ai < bi); end
            3'd2: begin
                p  = (2*W)'(ai * bi);
                lo = p[W-1:0];
                hi = p[2*W-1:W];
                c  = (hi != '0);
            end
            3'd3: begin
`ifdef ALU_DIV_EN
                if (bi == 0) begin lo = '1; hi = a; e = 1'b1; end
                else begin lo = W'(ai / bi); hi = W'(ai % bi); end
`else
                e = 1'b1;
`endif
            end
            3'd4: lo = a & b;
            3'd5: lo = a | b;
            3'd6: lo = a ^ b;
            default: lo = ~(a ^ b);
        endcase
        return {lo, hi, c, (lo == '0), e};
    endfunction

    function automatic int latency(input logic [W-1:0] b, input logic [2:0] sel);
        if (sel == 3'd2) return W + 1;
`ifdef ALU_DIV_EN
        if (sel == 3'd3 && b != '0) return W + 1;
`endif
        return 1;
    endfunction

    task automatic check_result(input string tag, input logic [RW-1:0] e);
        chk({tag, ".out"},    32'(OUT),    32'(e[RW-1 -: W]));
        chk({tag, ".out_hi"}, 32'(OUT_HI), 32'(e[W+2 -: W]));
        chk({tag, ".carry"},  32'(CARRY),  32'(e[2]));
        chk({tag, ".zero"},   32'(ZERO),   32'(e[1]));
        chk({tag, ".err"},    32'(ERR),    32'(e[0]));
    endtask

    // Driver: issue one operation, wait for its result, optionally apply
    // backpressure for 'hold' cycles, then complete the handoff.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] sel, input int hold);
        logic [RW-1:0] e;
        int lat;
        int exp_lat;
        exp_lat = latency(b, sel);
        @(negedge CLK);
        chk({tag, ".in_ready_idle"}, 32'(IN_READY), 32'd1);
        A = a; B = b; SEL = sel; IN_VALID = 1'b1;
        OUT_READY = (hold == 0);
        exp_q.push_back(model(a, b, sel));
        @(posedge CLK);                 // accept edge
        @(negedge CLK);
        IN_VALID = 1'b0;
        A = W'($urandom); B = W'($urandom); SEL = 3'($urandom);
        lat = 1;
        while (!OUT_VALID && lat < 100) begin
            chk({tag, ".in_ready_busy"}, 32'(IN_READY), 32'd0);
            @(negedge CLK);
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check_result(tag, e);
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                IN_VALID = 1'b1; A = W'($urandom); B = W'($urandom); SEL = 3'($urandom);
            end else begin
                IN_VALID = 1'b0;
            end
            @(negedge CLK);
            chk({tag, ".hold_valid"}, 32'(OUT_VALID), 32'd1);
            chk({tag, ".hold_in_ready"}, 32'(IN_READY), 32'd0);
            check_result({tag, ".hold"}, e);
        end
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        @(negedge CLK);                 // handoff edge has passed
        chk({tag, ".after_valid"}, 32'(OUT_VALID), 32'd0);
        chk({tag, ".after_in_ready"}, 32'(IN_READY), 32'd1);
        check_result({tag, ".kept"}, e);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [2:0]   rs;
        RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
        A = '0; B = '0; SEL = '0;
        #1;
        chk("reset.in_ready", 32'(IN_READY), 32'd0);
        chk("reset.out_valid", 32'(OUT_VALID), 32'd0);
        check_result("reset", '0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        run_op("add",     8'd200, 8'd100, 3'b000, 0);
        run_op("sub",     8'd5,   8'd7,   3'b001, 0);
        run_op("and",     8'hF0,  8'h0F,  3'b100, 0);
        run_op("mul",     8'd25,  8'd20,  3'b010, 0);
        run_op("div",     8'd200, 8'd7,   3'b011, 0);
        run_op("div0",    8'd200, 8'd0,   3'b011, 0);
        run_op("xor_bp",  8'hAA,  8'h0F,  3'b110, 5);
        run_op("or",      8'h81,  8'h18,  3'b101, 1);
        run_op("xnor",    8'h3C,  8'h3C,  3'b111, 0);
        run_op("div_big", 8'd255, 8'd1,   3'b011, 2);
        run_op("div_lt",  8'd3,   8'd200, 3'b011, 0);

        // Reset in the middle of a multiply
        @(negedge CLK);
        A = 8'hFF; B = 8'hFF; SEL = 3'b010; IN_VALID = 1'b1; OUT_READY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        IN_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("rst_mid.in_ready", 32'(IN_READY), 32'd0);
        chk("rst_mid.out_valid", 32'(OUT_VALID), 32'd0);
        check_result("rst_mid", '0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            chk("rst_mid.no_valid", 32'(OUT_VALID), 32'd0);
        end
        run_op("mul_ff", 8'hFF, 8'hFF, 3'b010, 0);

        // Random operations
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = (i % 6 == 0) ? '0 : W'($urandom_range(0, 255));
            rs = 3'($urandom_range(0, 7));
            run_op("rand", ra, rb, rs, $urandom_range(0, 2));
        end

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor to the team's 8-bit combinational ALU. It has the same eight SEL opcodes, plus a configurable WIDTH, a valid/ready handshake on input and output, and iterative shift-add multiply and restoring divide. Results are full double-width, and status flags are registered. It sits between an operand-issue stage and a result-writeback stage, and it holds one operation at a time.

## Interface
- WIDTH, default 8: operand and result width; legal range ≥ 2.
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- IN_VALID  input  1  operands and SEL are valid.
- IN_READY  output  1  block can accept an operation.
- A  input  WIDTH  operand A (unsigned).
- B  input  WIDTH  operand B (unsigned).
- SEL  input  3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 XNOR.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  consumer accepts the result.
- OUT  output  WIDTH  primary result: sum, difference, product low half, quotient, or logic result.
- OUT_HI  output  WIDTH  product high half (MUL), remainder (DIV), otherwise 0.
- CARRY  output  1  ADD carry-out, SUB borrow (A<B), MUL high half nonzero; otherwise 0.
- ZERO  output  1  OUT == 0.
- ERR  output  1  DIV with B == 0, or DIV when divide is compiled out.

## Operation
- FSM states: IDLE, BUSY, DONE.
- Reset values:
  - State is IDLE.
  - OUT, OUT_HI, CARRY, ZERO, ERR and OUT_VALID are all 0.
  - IN_READY is 0 while RST is high.
- IN_READY = (state == IDLE) and not RST. OUT_VALID = (state == DONE).
- Accept happens on an edge where IN_VALID && IN_READY. A, B and SEL are latched; later changes on the inputs are ignored.
- Transitions out of IDLE:
  - ADD, SUB, AND, OR, XOR, XNOR: the result is computed from the latched operands, registered, and the FSM goes to DONE.
  - MUL, and DIV with B ≠ 0: load the iteration registers, clear the counter, go to BUSY.
  - DIV with B == 0: go straight to DONE with OUT = all ones, OUT_HI = A, ERR = 1.
- BUSY behaviour:
  - One iteration per cycle for exactly WIDTH cycles; the counter is log2(WIDTH)+1 bits wide.
  - MUL uses shift-add on a 2·WIDTH accumulator.
  - DIV is restoring: shift the partial remainder left, trial-subtract B, and set the quotient bit if the subtraction does not go negative.
  - After the final iteration the result is written to OUT/OUT_HI and flags, and the FSM goes to DONE.
- Arithmetic rules:
  - ADD/SUB are mod 2^WIDTH, with the carry/borrow reported on CARRY.
  - MUL gives the exact 2·WIDTH product.
  - DIV gives floor(A/B), and OUT_HI = A mod B.
  - Logic ops, and DIV, set CARRY = 0.
- DONE behaviour:
  - All outputs are held stable while OUT_READY is low (backpressure).
  - On OUT_VALID && OUT_READY the FSM returns to IDLE. OUT, OUT_HI and the flags keep their last values; only OUT_VALID drops.
- IN_VALID is ignored in BUSY and DONE. No operation is queued, and none is dropped silently, because IN_READY is low in those states.
- Reset mid-operation (any state): the operation is aborted immediately, with no OUT_VALID for it, and all reset values are restored.

## Timing
- Accept at edge N.
- Single-cycle ops and DIV-by-zero: OUT_VALID is high from edge N+1.
- MUL and DIV (B ≠ 0): OUT_VALID is high from edge N+WIDTH+1.
- If OUT_READY is high in the first DONE cycle, the handoff is at edge N+2 (or N+WIDTH+2) and IN_READY is high in the following cycle.
- Peak throughput is one operation per 2 cycles (single-cycle ops) or per WIDTH+2 cycles (MUL/DIV).
- All outputs are registered or decoded from state; there is no combinational path from A/B/SEL to the outputs.

## Configuration
- The macro is ALU_DIV_EN.
- With ALU_DIV_EN defined:
  - The restoring divider is built.
  - DIV behaves as described above.
- Without ALU_DIV_EN:
  - No divider logic is built.
  - SEL = 011 completes as a single-cycle op: OUT = 0, OUT_HI = 0, CARRY = 0, ZERO = 1, ERR = 1.
  - MUL and all other opcodes are unaffected.

## Test plan
All scenarios use WIDTH = 8.
- ADD, A=200, B=100, OUT_READY=1: OUT=0x2C, CARRY=1, ZERO=0, OUT_VALID one cycle after accept.
- SUB, A=5, B=7: OUT=0xFE, CARRY=1. Then AND, A=0xF0, B=0x0F: OUT=0x00, ZERO=1, CARRY=0.
- MUL, A=25, B=20: OUT=0xF4, OUT_HI=0x01, CARRY=1, OUT_VALID exactly 9 cycles after accept; IN_READY=0 throughout.
- DIV, A=200, B=7: OUT=28, OUT_HI=4, ERR=0 after 9 cycles.
  - DIV, A=200, B=0: OUT=0xFF, OUT_HI=200, ERR=1 after 1 cycle.
  - Rebuilt without ALU_DIV_EN: DIV, A=200, B=7 gives OUT=0, ERR=1 after 1 cycle.
- Backpressure: hold OUT_READY=0 for 5 cycles after an XOR of 0xAA and 0x0F. OUT=0xA5 stays stable, and a second IN_VALID pulse is not accepted. Raising OUT_READY completes the handoff, and IN_READY rises the next cycle.
- Reset mid-MUL: assert RST 4 cycles into BUSY for 0xFF×0xFF.
  - All outputs go to 0 immediately, and OUT_VALID never pulses.
  - After release, MUL 0xFF×0xFF gives OUT=0x01, OUT_HI=0xFE.
